// File: rtl/bp_l15_arb_pkg.sv
// Shared types for the I$/D$ miss arbiter in front of the BP->L1.5 transducer.
package bp_l15_arb_pkg;

  typedef enum logic {e_idle = 1'b0, e_busy = 1'b1} bp_l15_arb_state_e;
  typedef enum logic {e_req_icache = 1'b0, e_req_dcache = 1'b1} bp_l15_req_id_e;

  localparam int unsigned data_mem_pkt_width_gp = 523;
  localparam int unsigned tag_mem_pkt_width_gp  = 42;
  localparam int unsigned stat_mem_pkt_width_gp = 11;

  function automatic bp_l15_req_id_e other_req(bp_l15_req_id_e id);
    if (id == e_req_icache) return e_req_dcache;
    else                    return e_req_icache;
  endfunction

endpackage

// File: rtl/bp_l15_req_mux.sv
// Owner-select mux of the miss request fields; outputs are zero unless enabled.
module bp_l15_req_mux
  import bp_l15_arb_pkg::*;
#(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned dword_width_p   = 64,
  parameter int unsigned lru_way_width_p = 3
) (
  input  logic                       en,
  input  logic                       owner,
  input  logic                       icache_uncached,
  input  logic [paddr_width_p-1:0]   icache_addr,
  input  logic [lru_way_width_p-1:0] icache_way,
  input  logic                       dcache_uncached,
  input  logic                       dcache_store,
  input  logic [paddr_width_p-1:0]   dcache_addr,
  input  logic [lru_way_width_p-1:0] dcache_way,
  input  logic [dword_width_p-1:0]   dcache_store_data,
  input  logic [1:0]                 dcache_size_op,
  output logic                       uncached,
  output logic                       store,
  output logic [paddr_width_p-1:0]   addr,
  output logic [lru_way_width_p-1:0] way,
  output logic [dword_width_p-1:0]   store_data,
  output logic [1:0]                 size_op
);

  always_comb begin
    uncached   = '0;
    store      = '0;
    addr       = '0;
    way        = '0;
    store_data = '0;
    size_op    = '0;
    if (en) begin
      if (owner == e_req_dcache) begin
        uncached   = dcache_uncached;
        store      = dcache_store;
        addr       = dcache_addr;
        way        = dcache_way;
        store_data = dcache_store_data;
        size_op    = dcache_size_op;
      end else begin
        // I$ misses are always full-dword loads
        uncached = icache_uncached;
        addr     = icache_addr;
        way      = icache_way;
        size_op  = 2'b11;
      end
    end
  end

endmodule

// File: rtl/bp_l15_miss_arbiter.sv
// Round-robin sharing of the single L1.5 transducer miss port between the I$ and D$,
// with fill and sync packet steering back to the owning cache.
module bp_l15_miss_arbiter
  import bp_l15_arb_pkg::*;
#(
  parameter  int unsigned paddr_width_p    = 40,
  parameter  int unsigned dword_width_p    = 64,
  parameter  int unsigned lce_assoc_p      = 8,
  localparam int unsigned lru_way_width_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              icache_miss_v_i,
  input  logic                              icache_uncached_i,
  input  logic [paddr_width_p-1:0]          icache_miss_addr_i,
  input  logic [lru_way_width_lp-1:0]       icache_lru_way_i,
  output logic                              icache_miss_yumi_o,
  input  logic                              dcache_miss_v_i,
  input  logic                              dcache_uncached_i,
  input  logic                              dcache_store_i,
  input  logic [paddr_width_p-1:0]          dcache_miss_addr_i,
  input  logic [lru_way_width_lp-1:0]       dcache_lru_way_i,
  input  logic [dword_width_p-1:0]          dcache_store_data_i,
  input  logic [1:0]                        dcache_size_op_i,
  output logic                              dcache_miss_yumi_o,
  output logic                              miss_v_o,
  output logic                              uncached_o,
  output logic                              store_o,
  output logic [paddr_width_p-1:0]          miss_addr_o,
  output logic [lru_way_width_lp-1:0]       lru_way_o,
  output logic [dword_width_p-1:0]          store_data_o,
  output logic [1:0]                        size_op_o,
  input  logic                              miss_yumi_i,
  input  logic                              ready_i,
  input  logic                              isync_i,
  input  logic                              dsync_i,
  input  logic [data_mem_pkt_width_gp-1:0]  data_mem_pkt_i,
  input  logic                              data_mem_pkt_v_i,
  output logic                              data_mem_pkt_yumi_o,
  input  logic [tag_mem_pkt_width_gp-1:0]   tag_mem_pkt_i,
  input  logic                              tag_mem_pkt_v_i,
  output logic                              tag_mem_pkt_yumi_o,
  input  logic [stat_mem_pkt_width_gp-1:0]  stat_mem_pkt_i,
  input  logic                              stat_mem_pkt_v_i,
  output logic                              stat_mem_pkt_yumi_o,
  output logic [data_mem_pkt_width_gp-1:0]  icache_data_mem_pkt_o,
  output logic                              icache_data_mem_pkt_v_o,
  input  logic                              icache_data_mem_pkt_yumi_i,
  output logic [tag_mem_pkt_width_gp-1:0]   icache_tag_mem_pkt_o,
  output logic                              icache_tag_mem_pkt_v_o,
  input  logic                              icache_tag_mem_pkt_yumi_i,
  output logic [stat_mem_pkt_width_gp-1:0]  icache_stat_mem_pkt_o,
  output logic                              icache_stat_mem_pkt_v_o,
  input  logic                              icache_stat_mem_pkt_yumi_i,
  output logic [data_mem_pkt_width_gp-1:0]  dcache_data_mem_pkt_o,
  output logic                              dcache_data_mem_pkt_v_o,
  input  logic                              dcache_data_mem_pkt_yumi_i,
  output logic [tag_mem_pkt_width_gp-1:0]   dcache_tag_mem_pkt_o,
  output logic                              dcache_tag_mem_pkt_v_o,
  input  logic                              dcache_tag_mem_pkt_yumi_i,
  output logic [stat_mem_pkt_width_gp-1:0]  dcache_stat_mem_pkt_o,
  output logic                              dcache_stat_mem_pkt_v_o,
  input  logic                              dcache_stat_mem_pkt_yumi_i
);

  bp_l15_arb_state_e state_r, state_n;
  bp_l15_req_id_e    owner_r, owner_n, last_r, last_n, winner;
  logic              busy, owner_miss_v;

  assign busy         = (state_r == e_busy);
  assign owner_miss_v = (owner_r == e_req_dcache) ? dcache_miss_v_i : icache_miss_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      owner_r <= e_req_icache;
      last_r  <= e_req_dcache;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
    end
  end

  always_comb begin
    state_n            = state_r;
    owner_n            = owner_r;
    last_n             = last_r;
    winner             = e_req_icache;
    miss_v_o           = 1'b0;
    icache_miss_yumi_o = 1'b0;
    dcache_miss_yumi_o = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (ready_i && (icache_miss_v_i || dcache_miss_v_i)) begin
          if (icache_miss_v_i && dcache_miss_v_i) winner = other_req(last_r);
          else if (dcache_miss_v_i)               winner = e_req_dcache;
          state_n = e_busy;
          owner_n = winner;
          last_n  = winner;
        end
      end
      e_busy: begin
        miss_v_o = owner_miss_v;
        if (miss_yumi_i) begin
          icache_miss_yumi_o = (owner_r == e_req_icache);
          dcache_miss_yumi_o = (owner_r == e_req_dcache);
          state_n            = e_idle;
        end
      end
    endcase
  end

  bp_l15_req_mux #(
    .paddr_width_p  (paddr_width_p),
    .dword_width_p  (dword_width_p),
    .lru_way_width_p(lru_way_width_lp)
  ) req_mux (
    .en               (busy),
    .owner            (owner_r),
    .icache_uncached  (icache_uncached_i),
    .icache_addr      (icache_miss_addr_i),
    .icache_way       (icache_lru_way_i),
    .dcache_uncached  (dcache_uncached_i),
    .dcache_store     (dcache_store_i),
    .dcache_addr      (dcache_miss_addr_i),
    .dcache_way       (dcache_lru_way_i),
    .dcache_store_data(dcache_store_data_i),
    .dcache_size_op   (dcache_size_op_i),
    .uncached         (uncached_o),
    .store            (store_o),
    .addr             (miss_addr_o),
    .way              (lru_way_o),
    .store_data       (store_data_o),
    .size_op          (size_op_o)
  );

  // Sync invalidations override fill ownership: tag/stat go to the sync target, data is held back.
  logic data_to_i, data_to_d, meta_to_i, meta_to_d;
  always_comb begin
    data_to_i = busy && (owner_r == e_req_icache);
    data_to_d = busy && (owner_r == e_req_dcache);
    meta_to_i = data_to_i;
    meta_to_d = data_to_d;
    if (isync_i || dsync_i) begin
      data_to_i = 1'b0;
      data_to_d = 1'b0;
      meta_to_i = isync_i;
      meta_to_d = !isync_i;
    end
  end

  assign icache_data_mem_pkt_o   = data_mem_pkt_i;
  assign dcache_data_mem_pkt_o   = data_mem_pkt_i;
  assign icache_tag_mem_pkt_o    = tag_mem_pkt_i;
  assign dcache_tag_mem_pkt_o    = tag_mem_pkt_i;
  assign icache_stat_mem_pkt_o   = stat_mem_pkt_i;
  assign dcache_stat_mem_pkt_o   = stat_mem_pkt_i;

  assign icache_data_mem_pkt_v_o = data_mem_pkt_v_i & data_to_i;
  assign dcache_data_mem_pkt_v_o = data_mem_pkt_v_i & data_to_d;
  assign icache_tag_mem_pkt_v_o  = tag_mem_pkt_v_i  & meta_to_i;
  assign dcache_tag_mem_pkt_v_o  = tag_mem_pkt_v_i  & meta_to_d;
  assign icache_stat_mem_pkt_v_o = stat_mem_pkt_v_i & meta_to_i;
  assign dcache_stat_mem_pkt_v_o = stat_mem_pkt_v_i & meta_to_d;

  assign data_mem_pkt_yumi_o = (data_to_i & icache_data_mem_pkt_yumi_i) | (data_to_d & dcache_data_mem_pkt_yumi_i);
  assign tag_mem_pkt_yumi_o  = (meta_to_i & icache_tag_mem_pkt_yumi_i)  | (meta_to_d & dcache_tag_mem_pkt_yumi_i);
  assign stat_mem_pkt_yumi_o = (meta_to_i & icache_stat_mem_pkt_yumi_i) | (meta_to_d & dcache_stat_mem_pkt_yumi_i);

  a_no_stray_fill: assert property (@(posedge clk_i) disable iff (reset_i)
    (!busy && !isync_i && !dsync_i) |-> !(data_mem_pkt_v_i || tag_mem_pkt_v_i || stat_mem_pkt_v_i));

  a_owner_holds_miss: assert property (@(posedge clk_i) disable iff (reset_i)
    busy |-> owner_miss_v);

endmodule

// File: doc/bp_l15_miss_arbiter.md
# bp_l15_miss_arbiter

Shares the single BP→L1.5 transducer miss port between the BlackParrot I$ and D$. It arbitrates round-robin between the two miss requesters and holds the grant until the transducer retires the miss. It steers the transducer's data, tag and stat fill packets back to the owning cache, and routes isync/dsync invalidation packets to the I$ or D$ respectively. It sits between the two caches and the L1.5 transducer in the tile.

## Interface
- paddr_width_p, 40, physical address width
- dword_width_p, 64, store data width
- lce_assoc_p, 8, ways; lru_way width = `BSG_SAFE_CLOG2(lce_assoc_p)`
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- icache_miss_v_i / icache_uncached_i  in  1 / 1  I$ miss request, load only
- icache_miss_addr_i / icache_lru_way_i  in  paddr_width_p / 3  I$ miss address and victim way
- icache_miss_yumi_o  out  1  I$ miss retired
- dcache_miss_v_i / dcache_uncached_i / dcache_store_i  in  1 each  D$ miss request
- dcache_miss_addr_i / dcache_lru_way_i  in  paddr_width_p / 3  D$ miss address and victim way
- dcache_store_data_i / dcache_size_op_i  in  64 / 2  D$ store data and size
- dcache_miss_yumi_o  out  1  D$ miss retired
- miss_v_o, uncached_o, store_o  out  1 each  to transducer
- miss_addr_o, lru_way_o, store_data_o, size_op_o  out  40/3/64/2  to transducer
- miss_yumi_i  in  1  transducer retired the miss
- ready_i, isync_i, dsync_i  in  1 each  transducer status
- data_mem_pkt_i / data_mem_pkt_v_i / data_mem_pkt_yumi_o  in/in/out  523/1/1  fill from transducer
- tag_mem_pkt_i / tag_mem_pkt_v_i / tag_mem_pkt_yumi_o  in/in/out  42/1/1
- stat_mem_pkt_i / stat_mem_pkt_v_i / stat_mem_pkt_yumi_o  in/in/out  11/1/1
- {icache,dcache}_{data,tag,stat}_mem_pkt_o / _v_o  out  523/42/11 and 1  per-cache fill
- {icache,dcache}_{data,tag,stat}_mem_pkt_yumi_i  in  1  per-cache accept

## Operation
- States: e_idle, e_busy. Registers: state_r, owner_r (0 = I$, 1 = D$), last_r (last granted).
- e_idle: if ready_i and any miss_v, grant using round-robin on last_r. On a tie, grant the requester that is not last_r. Set owner_r and last_r to the winner, then go to e_busy. miss_v_o = 0.
- e_busy: miss_v_o = owner's miss_v. All transducer fields are muxed combinationally from the owner. For I$: store_o = 0, size_op_o = 2'b11, store_data_o = 0. Requesters hold fields stable until their yumi.
- miss_yumi_i in e_busy: pulse owner's miss_yumi_o in the same cycle (combinational), return to e_idle. The non-owner yumi is always 0.
- Fill steering in e_busy: each pkt bus fans out to both caches. {data,tag,stat}_v_o = v_i & (owner selected). Upstream yumi_o = owner's yumi_i.
- isync_i (any state): tag/stat v routed to I$ only, data v never routed. dsync_i: same, routed to D$. isync_i and dsync_i are never both high; if they are, isync_i wins.
- Packets valid in e_idle without sync are not forwarded: yumi_o = 0. Flag with an assertion.
- Requester dropping miss_v while owner in e_busy is illegal (assertion). The arbiter stays busy.

## Timing
- Reset values: state_r = e_idle, owner_r = 0, last_r = 1 (I$ wins first tie). All outputs 0.
- Grant latency: request seen in e_idle at cycle N → miss_v_o high at N+1.
- Minimum gap: yumi at cycle M → e_idle at M+1 → next miss_v_o at M+2.
- Fill v/yumi paths are purely combinational. There is no added cycle.
- Reset mid-miss returns to e_idle at the next edge and drops ownership. The transducer is reset in the same cycle.

## Structure
- Package bp_l15_arb_pkg holds:
  - enum bp_l15_arb_state_e {e_idle, e_busy}
  - enum bp_l15_req_id_e {e_req_icache = 0, e_req_dcache = 1}
- Sub-module bp_l15_req_mux: combinational owner-select mux of the request fields (address, way, store, data, size).
- Arbitration logic stays inline.

## Test plan
- Single I$ miss at addr 40'h80001040, way 3 → miss_addr_o = 40'h80001040 one cycle after request. Yumi → icache_miss_yumi_o pulses for exactly 1 cycle.
- I$ and D$ request simultaneously from reset → I$ granted first, D$ granted at yumi+2. Repeat with both held → grants alternate I, D, I, D.
- D$ uncached store 0xDEADBEEF, size_op 2'b10, owner D$ → store_o = 1, store_data_o passed. No I$ pkt valids for the whole miss.
- D$ cached miss with data_mem_pkt_v_i and tag_mem_pkt_v_i held 2 cycles while dcache yumi_i = 0 → upstream yumi_o stays 0, then 1 in the cycle dcache yumi_i = 1.
- isync_i for 64 cycles with tag/stat v → only I$ tag/stat v toggle. Then dsync_i for 64 cycles → only D$ tag/stat v toggle. Data v stays 0 throughout.
- reset_i asserted in e_busy (owner D$) → next cycle miss_v_o = 0 and all yumi = 0. A pending I$ request wins first after reset.
